// File: rtl/i2s_mic_capture.sv
// I2S receiver for a four-line MEMS mic array: drives ws, deserializes
// sd1..sd4 into signed samples and streams one word per slot.
module i2s_mic_capture #(
  parameter int SAMPLE_W = 24,
  parameter int DLY      = 2,
  parameter int FCNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  output logic                       ws,
  input  logic                       sd1,
  input  logic                       sd2,
  input  logic                       sd3,
  input  logic                       sd4,
  output logic signed [SAMPLE_W-1:0] out_data0,
  output logic signed [SAMPLE_W-1:0] out_data1,
  output logic signed [SAMPLE_W-1:0] out_data2,
  output logic signed [SAMPLE_W-1:0] out_data3,
  output logic                       out_right,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  input  logic                       clear_ovf,
  output logic [FCNT_W-1:0]          frame_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam logic [4:0] FIRST = 5'(DLY);
  localparam logic [4:0] LAST  = 5'(DLY + SAMPLE_W - 1);

  logic [1:0]                 state_q, state_d;
  logic [5:0]                 cnt_q, cnt_d;
  logic                       skip_q, skip_d;
  logic [3:0][SAMPLE_W-1:0]   sh_q, sh_d;
  logic [3:0][SAMPLE_W-1:0]   dat_q, dat_d;
  logic                       right_q, right_d;
  logic                       valid_q, valid_d;
  logic                       ovf_q, ovf_d;
  logic [FCNT_W-1:0]          fcnt_q, fcnt_d;

  logic [3:0] sd;
  logic       active;
  logic       in_win;
  logic       done;
  logic       emit;
  logic       xfer;

  assign sd     = {sd4, sd3, sd2, sd1};
  assign active = (state_q != S_IDLE);
  assign in_win = active && (cnt_q[4:0] >= FIRST)
                         && (cnt_q[4:0] <= LAST);
  assign done   = in_win && (cnt_q[4:0] == LAST);
  // first left word after start is junk: mics have not seen a ws edge
  assign emit   = done && !(skip_q && !cnt_q[5]);
  assign xfer   = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 6'd1;
    skip_d  = skip_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end
      end
      state_q == S_RUN: begin
        if (!en) state_d = S_STOP;
      end
      state_q == S_STOP: begin
        if (en) state_d = S_RUN;
        else if (cnt_q == 6'd63) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (done && !cnt_q[5]) skip_d = 1'b0;
  end

  always_comb begin
    sh_d = sh_q;
    for (int i = 0; i < 4; i++) begin
      if (in_win) sh_d[i] = {sh_q[i][SAMPLE_W-2:0], sd[i]};
    end
  end

  always_comb begin
    dat_d   = dat_q;
    right_d = right_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    fcnt_d  = fcnt_q;
    if (xfer) begin
      valid_d = 1'b0;
      if (right_q) fcnt_d = fcnt_q + FCNT_W'(1);
    end
    if (clear_ovf) ovf_d = 1'b0;
    if (emit) begin
      if (!valid_q || xfer) begin
        dat_d   = sh_d;
        right_d = cnt_q[5];
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      skip_q  <= 1'b1;
      sh_q    <= '0;
      dat_q   <= '0;
      right_q <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign ws        = cnt_q[5];
  assign out_data0 = dat_q[0];
  assign out_data1 = dat_q[1];
  assign out_data2 = dat_q[2];
  assign out_data3 = dat_q[3];
  assign out_right = right_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_i2s_mic_capture.sv
// Directed bench for i2s_mic_capture: slot timing, skip, backpressure,
// stop and async reset.
module tb_i2s_mic_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        ws;
  logic [3:0]  sdv;
  logic signed [23:0] od0, od1, od2, od3;
  logic        out_right;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        clear_ovf;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int bc = 0;
  int st = 0;
  logic [23:0] lw [4];
  logic [23:0] rw [4];

  always #5 clk = ~clk;

  i2s_mic_capture dut (
    .clk(clk), .reset_n(reset_n), .en(en), .ws(ws),
    .sd1(sdv[0]), .sd2(sdv[1]), .sd3(sdv[2]), .sd4(sdv[3]),
    .out_data0(od0), .out_data1(od1),
    .out_data2(od2), .out_data3(od3),
    .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow),
    .clear_ovf(clear_ovf), .frame_cnt(frame_cnt)
  );

  task automatic drive_sd();
    int p;
    logic [23:0] w;
    p = bc % 32;
    for (int k = 0; k < 4; k++) begin
      w = (bc >= 32) ? rw[k] : lw[k];
      sdv[k] = (st != 0 && p >= 2 && p <= 25) ? w[25-p] : 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    case (st)
      0: if (en) begin st = 1; bc = 0; end
      1: begin if (!en) st = 2; bc = (bc + 1) % 64; end
      default: begin
        if (en) st = 1;
        else if (bc == 63) st = 0;
        bc = (bc + 1) % 64;
      end
    endcase
    @(negedge clk);
    drive_sd();
  endtask

  task automatic tick_to(input int t);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(bc == t && st != 0) && n < 200);
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL tick_to timeout got bc=%0d need %0d", bc, t);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin lw[k] = '0; rw[k] = '0; end
    st = 0; bc = 0; sdv = '0;
    repeat (3) @(negedge clk);
    checks++; if (ws !== 1'b0) begin errors++; $display("FAIL rst_ws got %b exp 0", ws); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_fcnt got %0d exp 0", frame_cnt); end
    checks++; if (od0 !== 24'd0) begin errors++; $display("FAIL rst_data got %h exp 0", od0); end
    checks++; if (out_right !== 1'b0) begin errors++; $display("FAIL rst_right got %b exp 0", out_right); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int seen = 0;
    lw[0] = 24'h800001; rw[0] = 24'h7FFFFF;
    out_ready = 1'b1; en = 1'b1;
    tick();
    repeat (31) begin tick(); if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL basic_skip got %0d valid cycles exp 0", seen); end
    tick_to(58);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_r1_valid got %b exp 1", out_valid); end
    checks++; if (od0 !== 24'h7FFFFF) begin errors++; $display("FAIL basic_r1_data got %h exp 7fffff", od0); end
    tick_to(26);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_l_valid got %b exp 1", out_valid); end
    checks++; if (od0 !== 24'h800001) begin errors++; $display("FAIL basic_l_data got %h exp 800001", od0); end
    checks++; if (out_right !== 1'b0) begin errors++; $display("FAIL basic_l_right got %b exp 0", out_right); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_fcnt1 got %0d exp 1", frame_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_l_drop got %b exp 0", out_valid); end
    tick_to(58);
    checks++; if (od0 !== 24'h7FFFFF) begin errors++; $display("FAIL basic_r_data got %h exp 7fffff", od0); end
    checks++; if (out_right !== 1'b1) begin errors++; $display("FAIL basic_r_right got %b exp 1", out_right); end
    tick();
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL basic_fcnt2 got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_four_lines();
    lw[0] = 24'h111111; lw[1] = 24'h222222; lw[2] = 24'h333333; lw[3] = 24'h444444;
    for (int k = 0; k < 4; k++) rw[k] = lw[k];
    tick_to(26);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL four_valid got %b exp 1", out_valid); end
    checks++; if ({od0, od1, od2, od3} !== 96'h111111_222222_333333_444444) begin
      errors++; $display("FAIL four_left got %h %h %h %h exp 111111 222222 333333 444444", od0, od1, od2, od3);
    end
    tick_to(58);
    checks++; if ({od0, od1, od2, od3} !== 96'h111111_222222_333333_444444 || out_right !== 1'b1) begin
      errors++; $display("FAIL four_right got %h %h %h %h r=%b", od0, od1, od2, od3, out_right);
    end
    tick();
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL four_fcnt got %0d exp 3", frame_cnt); end
  endtask

  task automatic test_backpressure();
    tick_to(26);
    out_ready = 1'b0;
    lw[0] = 24'h5A5A5A; rw[0] = 24'hABCDEF;
    repeat (40) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", out_valid); end
    checks++; if (od0 !== 24'h111111) begin errors++; $display("FAIL bp_held got %h exp 111111", od0); end
    checks++; if (out_right !== 1'b0) begin errors++; $display("FAIL bp_right got %b exp 0", out_right); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b exp 1", overflow); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL bp_fcnt got %0d exp 3", frame_cnt); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_clear got %b exp 0", overflow); end
  endtask

  task automatic test_simultaneous();
    tick_to(25);
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sim_valid got %b exp 1", out_valid); end
    checks++; if (od0 !== 24'h5A5A5A) begin errors++; $display("FAIL sim_data got %h exp 5a5a5a", od0); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_ovf got %b exp 0", overflow); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL sim_fcnt got %0d exp 3", frame_cnt); end
  endtask

  task automatic test_stop();
    int hi = 0;
    int n = 0;
    tick_to(10);
    en = 1'b0;
    tick_to(26);
    checks++; if (out_valid !== 1'b1 || od0 !== 24'h5A5A5A) begin
      errors++; $display("FAIL stop_left got v=%b %h exp v=1 5a5a5a", out_valid, od0);
    end
    tick_to(40);
    checks++; if (ws !== 1'b1) begin errors++; $display("FAIL stop_ws_hi got %b exp 1", ws); end
    tick_to(58);
    checks++; if (out_valid !== 1'b1 || od0 !== 24'hABCDEF || out_right !== 1'b1) begin
      errors++; $display("FAIL stop_right got v=%b %h r=%b exp v=1 abcdef r=1", out_valid, od0, out_right);
    end
    while (st != 0 && n < 20) begin tick(); n++; end
    repeat (40) begin tick(); if (ws) hi++; end
    checks++; if (hi !== 0) begin errors++; $display("FAIL stop_idle_ws got %0d high cycles exp 0", hi); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stop_idle_valid got %b exp 0", out_valid); end
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL stop_fcnt got %0d exp 5", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b0; en = 1'b1;
    tick();
    tick_to(15); tick_to(15); tick_to(15);
    checks++; if (out_valid !== 1'b1 || overflow !== 1'b1 || out_right !== 1'b1) begin
      errors++; $display("FAIL rm_pre got v=%b ovf=%b r=%b exp 1 1 1", out_valid, overflow, out_right);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (ws !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rm_async got ws=%b v=%b exp 0 0", ws, out_valid);
    end
    checks++; if (overflow !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL rm_async2 got ovf=%b fcnt=%0d exp 0 0", overflow, frame_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1; st = 0; bc = 0; out_ready = 1'b1;
    drive_sd();
    tick();
    repeat (31) begin tick(); if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rm_skip got %0d valid cycles exp 0", seen); end
    tick_to(58);
    checks++; if (out_valid !== 1'b1 || od0 !== 24'hABCDEF || out_right !== 1'b1) begin
      errors++; $display("FAIL rm_right got v=%b %h r=%b exp v=1 abcdef r=1", out_valid, od0, out_right);
    end
    tick();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rm_fcnt got %0d exp 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_four_lines();
    test_backpressure();
    test_simultaneous();
    test_stop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_mic_capture.md
Name: i2s_mic_capture

Overview:
- I2S master-side receiver for the four-line MEMS microphone array: generates the word-select, deserializes sd1..sd4 into 24-bit signed samples, and presents one four-channel word per slot on a valid/ready stream.
- Sits directly downstream of the PLL-generated I2S bit clock and the microphone pins, and upstream of the sample FIFO / Avalon interface inside soc_system.
- Left slot carries the four left-channel mics and the right slot carries the four right-channel mics, giving 8 microphones total.

Parameters:
- SAMPLE_W, 24: valid bits per slot, MSB first.
- DLY, 2: bit offset from slot start (cnt[4:0]=0) to the MSB sample. Legal range 0..8, so that DLY+SAMPLE_W-1 <= 31.
- FCNT_W, 16: width of the frame counter.

Ports:
- clk, in, 1: I2S bit clock (sck). All logic is on the rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- en, in, 1: run request.
- ws, out, 1: I2S word-select driven to the mics; 0 = left slot.
- sd1, sd2, sd3, sd4, in, 1 each: serial data lines.
- out_data0, out_data1, out_data2, out_data3, out, SAMPLE_W each: signed samples for lines 1..4.
- out_right, out, 1: 1 = words came from the right slot.
- out_valid, out, 1: output word available.
- out_ready, in, 1: consumer accepts the word.
- overflow, out, 1: sticky flag, a completed word was dropped.
- clear_ovf, in, 1: synchronous clear of overflow.
- frame_cnt, out, FCNT_W: count of right-slot words accepted, wraps at 2^FCNT_W.

Behaviour:
- Reset (async, while reset_n=0): state=IDLE, cnt=0, ws=0, all shift registers 0, out_data*=0, out_right=0, out_valid=0, overflow=0, frame_cnt=0, skip=1.
- Counter: cnt is 6 bits. It increments mod 64 in RUN and STOP and is held at 0 in IDLE. ws is the direct flop bit cnt[5] (glitch-free), so one frame is 64 sck cycles.
- States:
  - IDLE: if en=1, go to RUN next edge; cnt starts counting from 0.
  - RUN: if en=0, go to STOP.
  - STOP: continue the frame; when cnt=63, go to IDLE. If en returns to 1 while in STOP, go back to RUN.
  - IDLE -> RUN sets skip=1.
- Capture: on an edge where DLY <= cnt[4:0] <= DLY+SAMPLE_W-1, every line shifts left by one and takes its sd bit into the LSB.
  - On the edge with cnt[4:0] = DLY+SAMPLE_W-1, the completed word is {shift[SAMPLE_W-2:0], sd}, and out_right for that word = cnt[5].
  - Latency: out_data and out_valid update on that same edge, so they are visible the cycle after the LSB is sampled.
- Skip: the first left word after IDLE->RUN is discarded (the mics have not yet seen a ws edge). At the end of that left slot, skip is cleared.
- Handshake:
  - A transfer occurs when out_valid=1 and out_ready=1 on an edge.
  - out_data and out_right are stable while out_valid=1 and out_ready=0.
  - On transfer with no new word completing, out_valid goes to 0.
  - Word completes and (out_valid=0 or a transfer happens on the same edge): load the new word and set out_valid=1.
  - Word completes while out_valid=1 and out_ready=0: drop the new word and set overflow=1. The held word is unchanged.
- frame_cnt increments on each transfer with out_right=1.
- clear_ovf=1 clears overflow. If a drop happens on the same edge, overflow stays set (set wins).
- Stopping: words completed in STOP are still emitted. In IDLE, no new words are generated, but a pending out_valid stays until it is accepted.
- Reset mid-frame: all state returns to reset values immediately. The partial word is lost and nothing is emitted.

Test Plan:
- Basic capture: en=1, DLY=2, sd1 drives left=0x800001 and right=0x7FFFFF in frame 2 -> out_data0=0x800001, out_right=0 at cnt=26 of the left slot; then out_data0=0x7FFFFF, out_right=1 at cnt=58. No word is emitted in frame 1's left slot.
- Four lines: sd1..sd4 carry 0x111111, 0x222222, 0x333333, 0x444444 -> all four outputs match in the same valid cycle, with out_ready held at 1.
- Backpressure: out_ready=0 for 40 cycles after a left word -> the left word is held, the right word is dropped, overflow=1, frame_cnt does not change. Pulse clear_ovf -> overflow=0.
- Simultaneous accept: out_ready goes 1 exactly on the completion edge of the next word -> the new word is loaded, out_valid stays 1, overflow stays 0.
- Stop mid-frame: drop en at cnt=10 -> the frame finishes, ws returns to 0, state IDLE after cnt=63, and the left and right words of that frame are both emitted.
- Async reset at cnt=15 -> ws, out_valid, overflow and frame_cnt are 0 immediately. After release with en=1, the first left word is skipped again.
